multi_ball_engine: RTL and testbench
====================================

// Module: multi_ball_engine
// PURPOSE
//   Parametrised N-ball bouncing-sprite engine for the 256x240 video pipeline.
//   Consumes hpos/vpos/display_on/vsync from the sync generator, updates every ball once per frame
//   from a synchronous vsync-edge FSM (one ball per clk, during vblank), and reflects balls off all four borders.
//   Renders balls with per-ball colour and fixed priority to a registered 3-bit rgb output.
// PARAMETERS
//   N_BALLS    4    number of balls, 1..8
//   BALL_SIZE  4    ball edge length in pixels
//   H_MAX      256  playfield width; legal x = 0..H_MAX-BALL_SIZE
//   V_MAX      240  playfield height; legal y = 0..V_MAX-BALL_SIZE
//   SPEED      2    initial |dx| = |dy| in pixels/frame, 1..15
//   INIT_X     128  x of ball 0 at reset
//   INIT_Y     128  y of ball 0 at reset
//   SPACING    16   x/y offset between consecutive balls at reset; INIT+(N_BALLS-1)*SPACING must be legal
// PORTS
//   clk           in   1   pixel clock
//   reset         in   1   reset, asynchronous, active-high
//   hpos          in   9   beam x from sync generator
//   vpos          in   9   beam y from sync generator
//   display_on    in   1   beam in visible area
//   vsync         in   1   vertical sync (same clk domain)
//   pause         in   1   1 = freeze motion
//   rgb           out  3   {b,g,r} pixel, registered
//   busy          out  1   1 while UPDATE in progress
//   frame_done    out  1   1-clk pulse when all balls updated
//   bounce_count  out  16  only with MB_BOUNCE_COUNT_EN
// BEHAVIOUR
//   Reset: rgb=0, busy=0, frame_done=0, FSM=IDLE, idx=0; ball i: x=INIT_X+i*SPACING, y=INIT_Y+i*SPACING,
//     dx=+SPEED (i even) / -SPEED (i odd), dy=+SPEED. Reset mid-UPDATE aborts immediately to these values.
//   vsync edge: vsync_q registered; rise = vsync & ~vsync_q. Only clk domain logic, no posedge vsync clocking.
//   FSM IDLE: on rise && !pause -> UPDATE, idx=0. rise with pause=1 -> stay IDLE, no pulse.
//   FSM UPDATE: busy=1; update ball idx this clk; idx==N_BALLS-1 -> DONE else idx+1. rise during UPDATE ignored.
//   FSM DONE: frame_done=1 for exactly this clk, busy=0, -> IDLE. Total: rise at clk T -> frame_done at T+N_BALLS+1.
//   Per-axis update (10-bit signed math, nx = pos + vel):
//     nx >= MAX-BALL_SIZE -> pos=MAX-BALL_SIZE, vel=-vel (bounce)
//     nx <= 0              -> pos=0, vel=-vel (bounce)
//     else pos=nx, vel unchanged. x and y independent; corner hit bounces both.
//   Render: hit_i = (hpos-x_i)<BALL_SIZE && (vpos-y_i)<BALL_SIZE, 9-bit unsigned wrap differences.
//     colour_i = (i mod 7)+1; lowest index wins on overlap.
//     rgb <= display_on ? (any hit ? colour of winner : 3'b000) : 3'b000; latency 1 clk from hpos/vpos.
//   Positions change only in UPDATE (vblank), so no mid-frame tearing; rendering continues while busy.
// CONFIGURATION
//   MB_BOUNCE_COUNT_EN defined: bounce_count port present; +1 per axis bounce (corner = +2),
//     saturates at 16'hFFFF, reset to 0, unaffected by pause.
//   MB_BOUNCE_COUNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//   Reset release, hpos=128,vpos=128,display_on=1 -> rgb=3'b001 next clk; display_on=0 -> rgb=0.
//   One vsync rise -> busy high 4 clks, frame_done pulse at T+5; ball0 at (130,130), ball1 at (142,146).
//   62 frames -> ball0 x=252, dx=-2; frame 63 x=250. Ball1 frame 72 x=0, dx=+2; frame 73 x=2.
//   Ball0 y: frame 54 y=236, dy=-2; with MB_BOUNCE_COUNT_EN bounce_count increments on each event, saturates at FFFF when preloaded.
//   SPACING=0 override: all balls overlap at (128,128) -> rgb=3'b001 (ball0 priority).
//   pause=1 across 3 vsync rises -> no busy, no frame_done, positions unchanged; reset at UPDATE idx=2 -> busy=0, init positions.

Source files
------------

// File: rtl/multi_ball_engine.sv
// multi_ball_engine: N-ball bouncing-sprite engine for a 256x240 raster.
// Balls advance once per frame. A vsync-edge FSM updates one ball per clk
// during vblank. Each ball reflects off all four playfield borders.
// Rendering gives each ball its own colour. On overlap the lowest index wins.
// The rgb output is registered, one clk after hpos/vpos.
// Optional feature: define MB_BOUNCE_COUNT_EN to add the saturating
// bounce_count output. Without it the port and the counter are absent.
module multi_ball_engine #(
  parameter int N_BALLS   = 4,
  parameter int BALL_SIZE = 4,
  parameter int H_MAX     = 256,
  parameter int V_MAX     = 240,
  parameter int SPEED     = 2,
  parameter int INIT_X    = 128,
  parameter int INIT_Y    = 128,
  parameter int SPACING   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] hpos,
  input  logic [8:0] vpos,
  input  logic       display_on,
  input  logic       vsync,
  input  logic       pause,
  output logic [2:0] rgb,
  output logic       busy,
  output logic       frame_done
`ifdef MB_BOUNCE_COUNT_EN
  ,
  output logic [15:0] bounce_count
`endif
);

  localparam logic signed [9:0] X_LIM = 10'(H_MAX - BALL_SIZE);
  localparam logic signed [9:0] Y_LIM = 10'(V_MAX - BALL_SIZE);

  typedef enum logic [1:0] {ST_IDLE, ST_UPDATE, ST_DONE} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  idx_reg, idx_next;
  logic        vsync_q;
  logic        rise;
  logic [2:0]  rgb_reg, rgb_next;

  logic [8:0]        ball_x  [N_BALLS];
  logic [8:0]        ball_y  [N_BALLS];
  logic signed [9:0] ball_dx [N_BALLS];
  logic signed [9:0] ball_dy [N_BALLS];
  logic [N_BALLS-1:0] hit;
  logic [2:0]         colour [N_BALLS];

  logic [8:0]        sel_x, sel_y;
  logic signed [9:0] sel_dx, sel_dy;
  logic [19:0]       x_step, y_step;   // {pos, vel, bounced}
  logic              upd_en;

  // One axis of motion: step, then clamp to a border and reverse on contact.
  function automatic logic [19:0] axis_step(input logic [8:0] pos,
                                            input logic signed [9:0] vel,
                                            input logic signed [9:0] lim);
    logic signed [9:0] nx;
    logic signed [9:0] nvel;
    nx   = $signed({1'b0, pos}) + vel;
    nvel = -vel;
    if (nx >= lim)
      axis_step = {lim[8:0], nvel, 1'b1};
    else if (nx <= 10'sd0)
      axis_step = {9'd0, nvel, 1'b1};
    else
      axis_step = {nx[8:0], vel, 1'b0};
  endfunction

  assign rise   = vsync & ~vsync_q;
  assign upd_en = (state_reg == ST_UPDATE);

  // Register vsync so that its edge can be detected inside the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vsync_q <= 1'b0;
    else       vsync_q <= vsync;
  end

  // FSM state and ball index registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      idx_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  // FSM next state and outputs. In UPDATE the FSM sweeps one ball per clk.
  // A vsync rise that arrives during UPDATE is ignored.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (rise && !pause) begin
          state_next = ST_UPDATE;
          idx_next   = 3'd0;
        end
      end
      ST_UPDATE: begin
        busy = 1'b1;
        if (idx_reg == 3'(N_BALLS - 1)) state_next = ST_DONE;
        else                            idx_next   = idx_reg + 3'd1;
      end
      ST_DONE: begin
        frame_done = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Select the ball under update and compute its next motion state.
  always_comb begin
    sel_x  = ball_x[0];
    sel_y  = ball_y[0];
    sel_dx = ball_dx[0];
    sel_dy = ball_dy[0];
    for (int i = 1; i < N_BALLS; i++) begin
      if (idx_reg == 3'(i)) begin
        sel_x  = ball_x[i];
        sel_y  = ball_y[i];
        sel_dx = ball_dx[i];
        sel_dy = ball_dy[i];
      end
    end
    x_step = axis_step(sel_x, sel_dx, X_LIM);
    y_step = axis_step(sel_y, sel_dy, Y_LIM);
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_BALLS; gi++) begin : g_ball
      localparam logic [8:0]        X0  = 9'(INIT_X + gi * SPACING);
      localparam logic [8:0]        Y0  = 9'(INIT_Y + gi * SPACING);
      localparam logic signed [9:0] DX0 = (gi % 2 == 0) ? 10'(SPEED) : 10'(-SPEED);
      localparam logic signed [9:0] DY0 = 10'(SPEED);

      logic [8:0]        x_reg, y_reg;
      logic signed [9:0] dx_reg, dy_reg;
      logic [8:0]        dh, dv;

      // Ball state. It is written only while the FSM points at this ball.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          x_reg  <= X0;
          y_reg  <= Y0;
          dx_reg <= DX0;
          dy_reg <= DY0;
        end else if (upd_en && idx_reg == 3'(gi)) begin
          x_reg  <= x_step[19:11];
          dx_reg <= x_step[10:1];
          y_reg  <= y_step[19:11];
          dy_reg <= y_step[10:1];
        end
      end

      assign ball_x[gi]  = x_reg;
      assign ball_y[gi]  = y_reg;
      assign ball_dx[gi] = dx_reg;
      assign ball_dy[gi] = dy_reg;

      // A ball covers the pixel when both wrapped offsets fall inside the box.
      assign dh         = hpos - x_reg;
      assign dv         = vpos - y_reg;
      assign hit[gi]    = (dh < 9'(BALL_SIZE)) && (dv < 9'(BALL_SIZE));
      assign colour[gi] = 3'((gi % 7) + 1);
    end
  endgenerate

  // Pixel colour. Scanning from the top index down lets ball 0 win overlaps.
  always_comb begin
    rgb_next = 3'b000;
    for (int i = N_BALLS - 1; i >= 0; i--) begin
      if (hit[i]) rgb_next = colour[i];
    end
    if (!display_on) rgb_next = 3'b000;
  end

  // Registered pixel output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rgb_reg <= 3'b000;
    else       rgb_reg <= rgb_next;
  end

  assign rgb = rgb_reg;

`ifdef MB_BOUNCE_COUNT_EN
  logic [15:0] bounce_reg;
  logic [16:0] bounce_sum;
  assign bounce_sum = {1'b0, bounce_reg} + 17'(x_step[0]) + 17'(y_step[0]);

  // Count every axis reflection. A corner hit counts twice. Saturates at 16'hFFFF.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       bounce_reg <= 16'd0;
    else if (upd_en) bounce_reg <= bounce_sum[16] ? 16'hFFFF : bounce_sum[15:0];
  end

  assign bounce_count = bounce_reg;
`else
  logic unused_bounce;
  assign unused_bounce = x_step[0] | y_step[0];
`endif

endmodule

// File: tb/tb_multi_ball_engine.sv
// Testbench for multi_ball_engine with the default parameters.
// A second instance built with SPACING=0 checks the overlap priority.
// The bench keeps its own model of the balls, based on integer arithmetic.
// It compares rgb at probed pixels and the busy/frame_done timing against that model.
module tb_multi_ball_engine;
  localparam int N  = 4;
  localparam int BS = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] hpos, vpos;
  logic       display_on, vsync, pause;
  logic [2:0] rgb, rgb_s0;
  logic       busy, busy_s0, frame_done, frame_done_s0;
`ifdef MB_BOUNCE_COUNT_EN
  logic [15:0] bounce_count, bounce_count_s0;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multi_ball_engine u_dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
    .display_on(display_on), .vsync(vsync), .pause(pause),
    .rgb(rgb), .busy(busy), .frame_done(frame_done)
`ifdef MB_BOUNCE_COUNT_EN
    , .bounce_count(bounce_count)
`endif
  );

  multi_ball_engine #(.SPACING(0)) u_dut_s0 (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
    .display_on(display_on), .vsync(vsync), .pause(pause),
    .rgb(rgb_s0), .busy(busy_s0), .frame_done(frame_done_s0)
`ifdef MB_BOUNCE_COUNT_EN
    , .bounce_count(bounce_count_s0)
`endif
  );

  // ---------------- reference model ----------------
  int mx[N], my[N], mdx[N], mdy[N];
  int mbc;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i] = 128 + 16 * i;
      my[i] = 128 + 16 * i;
      mdx[i] = (i % 2 == 0) ? 2 : -2;
      mdy[i] = 2;
    end
    mbc = 0;
  endtask

  task automatic move(inout int p, inout int v, input int lim);
    int n;
    n = p + v;
    if (n >= lim) begin p = lim; v = -v; mbc = (mbc + 1 > 65535) ? 65535 : mbc + 1; end
    else if (n <= 0) begin p = 0; v = -v; mbc = (mbc + 1 > 65535) ? 65535 : mbc + 1; end
    else p = n;
  endtask

  task automatic model_frame();
    for (int i = 0; i < N; i++) begin
      move(mx[i], mdx[i], 256 - BS);
      move(my[i], mdy[i], 240 - BS);
    end
  endtask

  function automatic logic [2:0] model_rgb(input int h, input int v, input bit de);
    if (!de) return 3'b000;
    for (int i = 0; i < N; i++)
      if ((((h - mx[i]) & 511) < BS) && (((v - my[i]) & 511) < BS))
        return 3'((i % 7) + 1);
    return 3'b000;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check3(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%03b required=%03b t=%0t", name, act, exp, $time);
    end
  endtask

`ifdef MB_BOUNCE_COUNT_EN
  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
`endif

  task automatic probe(input int h, input int v, input bit de,
                       input logic [2:0] exp, input string name);
    @(negedge clk);
    hpos = 9'(h); vpos = 9'(v); display_on = de;
    @(posedge clk); #1;
    check3(name, rgb, exp);
  endtask

  task automatic model_probe(input int h, input int v, input bit de);
    probe(h & 511, v & 511, de, model_rgb(h & 511, v & 511, de), "rgb_model");
  endtask

  task automatic probe_balls();
    for (int i = 0; i < N; i++) begin
      model_probe(mx[i], my[i], 1);
      model_probe(mx[i] + BS - 1, my[i] + BS - 1, 1);
      model_probe(mx[i] + BS, my[i], 1);
      model_probe(mx[i] - 1, my[i] + 1, 1);
    end
    for (int r = 0; r < 3; r++)
      model_probe(int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
                  bit'($urandom_range(0, 1)));
  endtask

  // One vsync rise. Unpaused: busy for N clks, then a single frame_done clk.
  // With wiggle set, vsync drops and rises again inside UPDATE; that second rise must be ignored.
  task automatic do_frame(input bit paused, input bit wiggle, input int fno);
    @(negedge clk);
    pause = paused; vsync = 1'b1;
    if (!paused) begin
      for (int k = 1; k <= N + 1; k++) begin
        @(posedge clk); #1;
        check1("busy", busy, k <= N);
        check1("frame_done", frame_done, k == N + 1);
        check1("busy_s0", busy_s0, k <= N);
        if (wiggle && k == 1) vsync = 1'b0;
        if (wiggle && k == 2) vsync = 1'b1;
      end
      @(posedge clk); #1;
      check1("busy_after_done", busy, 1'b0);
      model_frame();
    end else begin
      for (int k = 1; k <= N + 2; k++) begin
        @(posedge clk); #1;
        check1("busy_paused", busy, 1'b0);
        check1("frame_done_paused", frame_done, 1'b0);
      end
    end
    @(negedge clk);
    vsync = 1'b0; pause = 1'b0;
`ifdef MB_BOUNCE_COUNT_EN
    check16("bounce_count", bounce_count, 16'(mbc));
`endif
    $display("frame %0d paused=%0d ball0=(%0d,%0d) ball1=(%0d,%0d)",
             fno, paused, mx[0], my[0], mx[1], my[1]);
  endtask

  // ---------------- reset-state vector table ----------------
  typedef struct {
    logic [8:0] h;
    logic [8:0] v;
    logic       de;
    logic [2:0] exp;
    logic [2:0] exp_s0;
  } vec_t;
  vec_t tbl[12];

  task automatic run_table();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      hpos = tbl[i].h; vpos = tbl[i].v; display_on = tbl[i].de;
      @(posedge clk); #1;
      check3($sformatf("tbl%0d_rgb", i), rgb, tbl[i].exp);
      check3($sformatf("tbl%0d_rgb_s0", i), rgb_s0, tbl[i].exp_s0);
      $display("vec %0d h=%0d v=%0d de=%0b rgb=%03b rgb_s0=%03b",
               i, tbl[i].h, tbl[i].v, tbl[i].de, rgb, rgb_s0);
    end
  endtask

  initial begin
    tbl[0]  = '{9'd128, 9'd128, 1'b1, 3'd1, 3'd1};
    tbl[1]  = '{9'd131, 9'd131, 1'b1, 3'd1, 3'd1};
    tbl[2]  = '{9'd132, 9'd128, 1'b1, 3'd0, 3'd0};
    tbl[3]  = '{9'd127, 9'd128, 1'b1, 3'd0, 3'd0};
    tbl[4]  = '{9'd144, 9'd144, 1'b1, 3'd2, 3'd0};
    tbl[5]  = '{9'd147, 9'd147, 1'b1, 3'd2, 3'd0};
    tbl[6]  = '{9'd160, 9'd160, 1'b1, 3'd3, 3'd0};
    tbl[7]  = '{9'd176, 9'd179, 1'b1, 3'd4, 3'd0};
    tbl[8]  = '{9'd128, 9'd128, 1'b0, 3'd0, 3'd0};
    tbl[9]  = '{9'd0,   9'd0,   1'b1, 3'd0, 3'd0};
    tbl[10] = '{9'd148, 9'd144, 1'b1, 3'd0, 3'd0};
    tbl[11] = '{9'd130, 9'd129, 1'b1, 3'd1, 3'd1};

    reset = 1'b1; hpos = 9'd128; vpos = 9'd128; display_on = 1'b1;
    vsync = 1'b0; pause = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check3("reset_rgb", rgb, 3'b000);
    check1("reset_busy", busy, 1'b0);
    check1("reset_frame_done", frame_done, 1'b0);
`ifdef MB_BOUNCE_COUNT_EN
    check16("reset_bounce", bounce_count, 16'd0);
    check16("reset_bounce_s0", bounce_count_s0, 16'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    run_table();

    // Deterministic run through the border events at known frame numbers.
    for (int f = 1; f <= 73; f++) begin
      do_frame(1'b0, f == 2, f);
      probe_balls();
      if (f == 1) begin
        probe(130, 130, 1, 3'd1, "f1_ball0");
        probe(129, 130, 1, 3'd0, "f1_left_of_ball0");
        probe(142, 146, 1, 3'd2, "f1_ball1");
      end
      if (f == 54) begin
        probe(236, 239, 1, 3'd1, "f54_ball0_bottom");
        probe(236, 240, 1, 3'd0, "f54_below_ball0");
      end
      if (f == 62) begin
        probe(252, 220, 1, 3'd1, "f62_ball0_right");
        probe(251, 220, 1, 3'd0, "f62_left_of_ball0");
      end
      if (f == 63) begin
        probe(250, 218, 1, 3'd1, "f63_ball0");
        probe(254, 218, 1, 3'd0, "f63_old_spot");
      end
      if (f == 72) probe(0, 184, 1, 3'd2, "f72_ball1_left");
      if (f == 73) begin
        probe(2, 182, 1, 3'd2, "f73_ball1");
        probe(1, 182, 1, 3'd0, "f73_left_of_ball1");
      end
    end

    // Three paused vsync rises: no activity, no motion.
    for (int f = 0; f < 3; f++) do_frame(1'b1, 1'b0, 74 + f);
    probe_balls();

    // Random mix of paused and running frames.
    for (int f = 0; f < 40; f++) begin
      do_frame(bit'($urandom_range(0, 3) == 0), 1'b0, 77 + f);
      probe_balls();
    end

    // Reset arriving while ball 2 is being updated.
    @(negedge clk);
    vsync = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check1("busy_before_abort", busy, 1'b1);
    reset = 1'b1;
    #1;
    check1("busy_abort", busy, 1'b0);
    check1("frame_done_abort", frame_done, 1'b0);
    check3("rgb_abort", rgb, 3'b000);
    @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    run_table();
    do_frame(1'b0, 1'b0, 1);
    probe_balls();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a hang.
  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
